// File: rtl/reg_status_file.sv
// Architectural register file with per-register rename status and ROB forwarding.
// Commits and renames update state on the clock edge; operand lookups are combinational.
module reg_status_file #(
  parameter int ROB_WIDTH_BIT = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     clear,
  input  logic [4:0]               set_reg_id,
  input  logic [31:0]              set_val,
  input  logic [ROB_WIDTH_BIT-1:0] set_reg_on_rob_id,
  input  logic [4:0]               set_dep_reg_id,
  input  logic [ROB_WIDTH_BIT-1:0] set_dep_rob_id,
  input  logic [4:0]               rs1,
  input  logic [4:0]               rs2,
  output logic [31:0]              val1,
  output logic                     has_dep1,
  output logic [ROB_WIDTH_BIT-1:0] dep1,
  output logic [31:0]              val2,
  output logic                     has_dep2,
  output logic [ROB_WIDTH_BIT-1:0] dep2,
  output logic [ROB_WIDTH_BIT-1:0] get_rob_id1,
  input  logic                     rob_value1_ready,
  input  logic [31:0]              rob_value1,
  output logic [ROB_WIDTH_BIT-1:0] get_rob_id2,
  input  logic                     rob_value2_ready,
  input  logic [31:0]              rob_value2
);

  logic [31:0]              regv_q [32];
  logic                     busy_q [32];
  logic [ROB_WIDTH_BIT-1:0] tag_q  [32];

  // The rename is applied after the commit so it wins when both target one register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int r = 0; r < 32; r++) begin
        regv_q[r] <= '0;
        busy_q[r] <= 1'b0;
        tag_q[r]  <= '0;
      end
    end else if (rdy_in) begin
      if (clear) begin
        for (int r = 0; r < 32; r++) begin
          busy_q[r] <= 1'b0;
          tag_q[r]  <= '0;
        end
      end else begin
        if (set_reg_id != 5'd0) begin
          regv_q[set_reg_id] <= set_val;
          if (busy_q[set_reg_id] && (tag_q[set_reg_id] == set_reg_on_rob_id)) begin
            busy_q[set_reg_id] <= 1'b0;
          end
        end
        if (set_dep_reg_id != 5'd0) begin
          busy_q[set_dep_reg_id] <= 1'b1;
          tag_q[set_dep_reg_id]  <= set_dep_rob_id;
        end
      end
    end
  end

  always_comb begin
    val1        = '0;
    has_dep1    = 1'b0;
    dep1        = '0;
    get_rob_id1 = '0;
    if (rs1 != 5'd0) begin
      if (busy_q[rs1]) begin
        get_rob_id1 = tag_q[rs1];
      end
      // A commit landing this cycle for the owning ROB entry is forwarded directly.
      if ((set_reg_id == rs1) && busy_q[rs1] && (tag_q[rs1] == set_reg_on_rob_id)) begin
        val1 = set_val;
      end else if (busy_q[rs1]) begin
        if (rob_value1_ready) begin
          val1 = rob_value1;
        end else begin
          has_dep1 = 1'b1;
          dep1     = tag_q[rs1];
        end
      end else begin
        val1 = regv_q[rs1];
      end
    end
  end

  always_comb begin
    val2        = '0;
    has_dep2    = 1'b0;
    dep2        = '0;
    get_rob_id2 = '0;
    if (rs2 != 5'd0) begin
      if (busy_q[rs2]) begin
        get_rob_id2 = tag_q[rs2];
      end
      if ((set_reg_id == rs2) && busy_q[rs2] && (tag_q[rs2] == set_reg_on_rob_id)) begin
        val2 = set_val;
      end else if (busy_q[rs2]) begin
        if (rob_value2_ready) begin
          val2 = rob_value2;
        end else begin
          has_dep2 = 1'b1;
          dep2     = tag_q[rs2];
        end
      end else begin
        val2 = regv_q[rs2];
      end
    end
  end

endmodule

// File: doc/reg_status_file.md
Name: reg_status_file

Overview:
- Architectural register file (x0–x31) with per-register rename status.
- Sits directly downstream of the reorder buffer. It consumes the ROB's commit write (set_reg_id / set_val / set_reg_on_rob_id) and rename tag (set_dep_reg_id / set_dep_rob_id).
- Serves the decoder's two source-operand lookups. A register still waiting on the ROB is forwarded through the ROB's value query ports (get_rob_id1/2 → rob_value1/2).
- Flush (clear) discards all pending renames. Committed values are kept.

Parameters:
ROB_WIDTH_BIT, 4, width of a ROB entry index; the ROB holds 2^ROB_WIDTH_BIT entries.

Ports:
clk_in  input  1  system clock; all state updates on the rising edge
rst_in  input  1  reset; asynchronous, active-low
rdy_in  input  1  ready; when low, no state changes
clear  input  1  flush from ROB; synchronous
set_reg_id  input  5  commit destination; 0 = no commit
set_val  input  32  commit value
set_reg_on_rob_id  input  ROB_WIDTH_BIT  ROB id of the committing entry
set_dep_reg_id  input  5  rename destination; 0 = no rename
set_dep_rob_id  input  ROB_WIDTH_BIT  ROB id now owning set_dep_reg_id
rs1  input  5  decoder source register 1
rs2  input  5  decoder source register 2
val1  output  32  operand 1 value (valid when has_dep1=0)
has_dep1  output  1  operand 1 still waits on the ROB
dep1  output  ROB_WIDTH_BIT  ROB id operand 1 waits on (0 when has_dep1=0)
val2, has_dep2, dep2  output  32/1/ROB_WIDTH_BIT  same for rs2
get_rob_id1  output  ROB_WIDTH_BIT  ROB lookup id for rs1
rob_value1_ready  input  1  ROB entry get_rob_id1 has its value (includes same-cycle RS/LSB broadcast)
rob_value1  input  32  value of ROB entry get_rob_id1
get_rob_id2, rob_value2_ready, rob_value2  out/in/in  ROB_WIDTH_BIT/1/32  same for rs2

Behaviour:
- State per register r: regv[r] (32b), busy[r] (1b), tag[r] (ROB_WIDTH_BIT).
  - x0: regv=0 and busy=0 always. Writes and renames to x0 are ignored.
- Reset (rst_in=0, async): all regv=0, busy=0, tag=0. Takes effect immediately, mid-operation included.
- Priority at the clock edge: reset > !rdy_in (hold everything) > clear > normal.
- clear=1 (with rdy_in=1):
  - All busy and tag cleared.
  - regv unchanged.
  - A commit or rename presented in the same cycle is ignored; those ROB entries are speculative and flushed.
- Normal cycle:
  - Commit: if set_reg_id≠0, regv[set_reg_id]←set_val.
    - If busy[set_reg_id] && tag==set_reg_on_rob_id, busy←0.
    - A tag mismatch means a younger renamer owns the register; busy and tag are then kept.
  - Rename: if set_dep_reg_id≠0, busy←1, tag←set_dep_rob_id.
  - Same register committed and renamed in one cycle: the value is written, and the rename wins (busy=1, tag=new id).
- Lookup is combinational, zero latency, for each port k (same rule for rs2/port 2):
  - rs=0 → val=0, has_dep=0, dep=0.
  - Commit bypass: if set_reg_id==rs && busy[rs] && tag[rs]==set_reg_on_rob_id → val=set_val, has_dep=0.
  - Else if busy[rs] → get_rob_id=tag[rs].
    - If rob_value_ready → val=rob_value, has_dep=0.
    - Otherwise val=0, has_dep=1, dep=tag[rs].
  - Else → val=regv[rs], has_dep=0.
  - get_rob_id=0 whenever the register is not busy.
  - Lookup reads pre-edge state. A rename issued in the same cycle, including the instruction's own rd, does not affect that cycle's lookup.
- Lookup outputs are valid regardless of clear or rdy_in; the consumer gates them.
- Outputs after reset: val=0, has_dep=0, dep=0, get_rob_id=0.

Test Plan:
- Reset, then rs1=5, rs2=0 → val1=0, has_dep1=0, val2=0; get_rob_id1=0.
- Rename x5→ROB 3, next cycle rs1=5, rob_value1_ready=0 → has_dep1=1, dep1=3, get_rob_id1=3. Then rob_value1_ready=1, rob_value1=0x1234 → val1=0x1234, has_dep1=0.
- x5 busy on tag 3; commit set_reg_id=5, set_reg_on_rob_id=3, set_val=0xAA with rs1=5 → val1=0xAA (bypass). Next cycle busy[5]=0 and regv[5]=0xAA.
- x7 renamed to tag 2, then to tag 6; commit x7 from tag 2 with value 9 → regv[7]=9, busy stays, tag=6. Same-cycle commit (tag 6) plus rename x7→tag 1 → busy=1, tag=1.
- x3 busy on tag 4; assert clear together with commit x3=0x55 and rename x9→tag 5 → all busy=0, regv[3] unchanged, x9 not busy. rs1=3 → old value, has_dep1=0.
- rdy_in=0 with commit x4=7 and rename x8 → no change. Writes or renames to x0 → x0 stays 0 and never busy. Async reset pulse mid-sequence → state zeroed without a clock edge.
